// File: rtl/hack_fetch_unit_pkg.sv
// rtl/hack_fetch_unit_pkg.sv - shared Hack widths, reset PC and FIFO sizing helpers
// Ports: none (package).
package hack_fetch_unit_pkg;

  localparam int HACK_ADDR_W     = 15;
  localparam int HACK_DATA_W     = 16;
  localparam int HACK_RESET_PC   = 0;
  localparam int HACK_FIFO_DEPTH = 2;

  // Occupancy needs one extra bit so that a full FIFO (occ == DEPTH) is representable.
  function automatic int hack_occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hack_fetch_unit_if.sv
// rtl/hack_fetch_unit_if.sv - ROM, redirect and instruction handshake bundle for the fetch stage
// Ports (signals):
//   rom_en/rom_addr          fetch -> ROM read strobe and address
//   rom_data                 ROM -> fetch, valid one cycle after rom_en
//   redirect_valid/_pc       ALU -> fetch jump target
//   instr_valid/_ready       fetch <-> decode handshake
//   instr_data/instr_pc      fetch -> decode instruction word and its address
interface hack_fetch_unit_if
  import hack_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
) ();

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  // Fetch unit side.
  modport master (
    output rom_en, rom_addr, instr_valid, instr_data, instr_pc,
    input  rom_data, redirect_valid, redirect_pc, instr_ready
  );

  // ROM / decode / ALU side.
  modport slave (
    input  rom_en, rom_addr, instr_valid, instr_data, instr_pc,
    output rom_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/hack_fetch_unit_sync_fifo.sv
// rtl/hack_fetch_unit_sync_fifo.sv - registered-output synchronous FIFO with flush
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, wdata       write request and word
//   pop               read request (head advances at the edge)
//   flush             empties the FIFO; priority over push/pop
//   rdata             head word, held in a register (holds last value when empty)
//   full, empty       status flags
//   occupancy         number of stored words
module hack_sync_fifo
  import hack_fetch_unit_pkg::*;
#(
  parameter int WIDTH = HACK_ADDR_W + HACK_DATA_W,
  parameter int DEPTH = HACK_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = hack_occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [WIDTH-1:0] r_rdata;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_rd_ptr_n;
  logic [OCC_W-1:0] w_occ_n;
  logic             w_bypass;

  assign full      = (r_occ == OCC_W'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occupancy = r_occ;
  assign rdata     = r_rdata;

  assign w_push_ok  = push & (~full | pop);
  assign w_pop_ok   = pop & ~empty;
  assign w_rd_ptr_n = r_rd_ptr + PTR_W'(w_pop_ok);
  assign w_occ_n    = r_occ + OCC_W'(w_push_ok) - OCC_W'(w_pop_ok);
  // The incoming word becomes the new head only when nothing older survives this edge.
  assign w_bypass   = w_push_ok & (r_occ == OCC_W'(w_pop_ok));

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_rdata  <= '0;
    end else if (flush) begin
      // Head register keeps its old value; instr_valid is already low via occupancy.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_occ    <= w_occ_n;
      if (w_occ_n != '0) begin
        r_rdata <= w_bypass ? wdata : r_mem[w_rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU instruction fetch: PC, ROM issue credit, redirect and instruction FIFO
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          hack_fetch_unit_if.master: rom_en/rom_addr/rom_data, redirect_valid/redirect_pc,
//                instr_valid/instr_ready/instr_data/instr_pc
module hack_fetch_unit
  import hack_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = HACK_ADDR_W,
  parameter int DATA_W   = HACK_DATA_W,
  parameter int DEPTH    = HACK_FIFO_DEPTH,
  parameter int RESET_PC = HACK_RESET_PC
) (
  input  logic clk,
  input  logic rst_n,
  hack_fetch_unit_if.master bus
);

  localparam int OCC_W = hack_occ_w(DEPTH);
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [OCC_W:0]    w_committed;
  logic              w_full;
  logic              w_empty;
  logic [OCC_W-1:0]  w_occ;
  logic [ENT_W-1:0]  w_head;

  assign w_pop = ~w_empty & bus.instr_ready;

  // Slots already spoken for after this edge: stored words plus the read in flight,
  // minus the word leaving now. Issuing only below DEPTH means a push never overflows.
  assign w_committed = {1'b0, w_occ} + (OCC_W+1)'(r_inflight) - (OCC_W+1)'(w_pop);
  assign w_issue     = rst_n & ~bus.redirect_valid & (w_committed < (OCC_W+1)'(DEPTH));

  // A redirect kills the response returning this cycle; reset is handled inside the FIFO.
  assign w_push = r_inflight & ~bus.redirect_valid & (~w_full | w_pop);

  assign bus.rom_en      = w_issue;
  assign bus.rom_addr    = r_pc;
  assign bus.instr_valid = ~w_empty;
  assign bus.instr_data  = w_head[ENT_W-1:ADDR_W];
  assign bus.instr_pc    = w_head[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= ADDR_W'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + ADDR_W'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  hack_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .wdata     ({bus.rom_data, r_inflight_pc}),
    .pop       (w_pop),
    .flush     (bus.redirect_valid),
    .rdata     (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .occupancy (w_occ)
  );

endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb/tb_hack_fetch_unit.sv - self-checking bench for hack_fetch_unit
module tb_hack_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  hack_fetch_unit_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  hack_fetch_unit #(
    .ADDR_W   (15),
    .DATA_W   (16),
    .DEPTH    (2),
    .RESET_PC (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [14:0] a);
    return 16'h1000 + {1'b0, a};
  endfunction

  // ROM model: word valid one cycle after rom_en, junk otherwise.
  always @(posedge clk) begin
    bus.rom_data <= bus.rom_en ? rom_fn(bus.rom_addr) : 16'hDEAD;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [14:0] rpc;
    logic        en;
    logic [14:0] addr;
    logic        valid;
    logic [15:0] data;
    logic [14:0] pc;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic rdy, input logic rd, input logic [14:0] rp,
                              input logic en, input logic [14:0] a, input logic v,
                              input logic [15:0] d, input logic [14:0] p);
    vec_t t;
    t.rst_n = r; t.ready = rdy; t.redir = rd; t.rpc = rp;
    t.en = en; t.addr = a; t.valid = v; t.data = d; t.pc = p;
    return t;
  endfunction

  initial begin
    logic [14:0] exp_pc;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [14:0] prev_pc;
    int          delivered;

    bus.rom_data       = 16'hDEAD;
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    //               rst   rdy   redir rpc       | en    addr      valid data      pc
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 15'h0000,  1'b0, 15'h0000, 1'b0, 16'h0000, 15'h0000);
    // streaming from reset: data appears in cycle 2, then one per cycle
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0000, 1'b0, 16'h0000, 15'h0000);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0001, 1'b0, 16'h0000, 15'h0000);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0002, 1'b1, 16'h1000, 15'h0000);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0003, 1'b1, 16'h1001, 15'h0001);
    // backpressure: issue stops at the credit limit, head stays put
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0004, 1'b1, 16'h1002, 15'h0002);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0004, 1'b1, 16'h1002, 15'h0002);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0004, 1'b1, 16'h1002, 15'h0002);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0004, 1'b1, 16'h1002, 15'h0002);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0004, 1'b1, 16'h1002, 15'h0002);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0005, 1'b1, 16'h1003, 15'h0003);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0006, 1'b1, 16'h1004, 15'h0004);
    // redirect with a word stored and a read in flight
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 15'h0100,  1'b0, 15'h0007, 1'b1, 16'h1005, 15'h0005);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0100, 1'b0, 16'h1005, 15'h0005);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0101, 1'b0, 16'h1005, 15'h0005);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0102, 1'b1, 16'h1100, 15'h0100);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0102, 1'b1, 16'h1100, 15'h0100);
    // redirect with the FIFO full, to 7FFE for the PC wrap
    vecs[17] = mk(1'b1, 1'b1, 1'b1, 15'h7FFE,  1'b0, 15'h0102, 1'b1, 16'h1100, 15'h0100);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h7FFE, 1'b0, 16'h1100, 15'h0100);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h7FFF, 1'b0, 16'h1100, 15'h0100);
    vecs[20] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0000, 1'b1, 16'h8FFE, 15'h7FFE);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0001, 1'b1, 16'h8FFF, 15'h7FFF);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0002, 1'b1, 16'h1000, 15'h0000);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 15'h0000,  1'b0, 15'h0003, 1'b1, 16'h1001, 15'h0001);
    // reset with the FIFO full, alongside a redirect: reset wins
    vecs[24] = mk(1'b0, 1'b1, 1'b1, 15'h0555,  1'b0, 15'h0003, 1'b1, 16'h1001, 15'h0001);
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0000, 1'b0, 16'h0000, 15'h0000);
    vecs[26] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0001, 1'b0, 16'h0000, 15'h0000);
    vecs[27] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0002, 1'b1, 16'h1000, 15'h0000);
    // reset with a read in flight: its returning word must not be pushed
    vecs[28] = mk(1'b0, 1'b1, 1'b0, 15'h0000,  1'b0, 15'h0003, 1'b1, 16'h1001, 15'h0001);
    vecs[29] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0000, 1'b0, 16'h0000, 15'h0000);
    vecs[30] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0001, 1'b0, 16'h0000, 15'h0000);
    vecs[31] = mk(1'b1, 1'b1, 1'b0, 15'h0000,  1'b1, 15'h0002, 1'b1, 16'h1000, 15'h0000);

    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n              = vecs[i].rst_n;
      bus.instr_ready    = vecs[i].ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d rom_en", i),      32'(bus.rom_en),      32'(vecs[i].en));
      check($sformatf("v%0d rom_addr", i),    32'(bus.rom_addr),    32'(vecs[i].addr));
      check($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d instr_data", i),  32'(bus.instr_data),  32'(vecs[i].data));
      check($sformatf("v%0d instr_pc", i),    32'(bus.instr_pc),    32'(vecs[i].pc));
    end

    // Random backpressure and redirects; delivered words must follow the redirect-defined path.
    exp_pc     = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_pc    = '0;
    delivered  = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      rst_n              = 1'b1;
      bus.instr_ready    = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.redirect_valid = (c == 0) || ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = 15'($urandom);
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(bus.instr_valid), 32'd1);
        check("hold_data",  32'(bus.instr_data),  32'(prev_data));
        check("hold_pc",    32'(bus.instr_pc),    32'(prev_pc));
      end
      if (c > 0 && bus.instr_valid && bus.instr_ready) begin
        check("sb_pc",   32'(bus.instr_pc),   32'(exp_pc));
        check("sb_data", 32'(bus.instr_data), 32'(rom_fn(exp_pc)));
        exp_pc = exp_pc + 15'd1;
        delivered++;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      prev_stall = bus.instr_valid & ~bus.instr_ready & ~bus.redirect_valid;
      prev_data  = bus.instr_data;
      prev_pc    = bus.instr_pc;
    end

    checks++;
    if (delivered < 2000) begin
      errors++;
      $display("FAIL delivered_count got %0d expected at least 2000", delivered);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
